// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared types and constants for the register file write-back arbiter
package rf_wb_pkg;

  localparam int XLEN       = 32;
  localparam int AW         = 5;
  localparam int N_WB_PORTS = 2;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_slot.sv
// rtl/rf_wb_slot.sv - one-entry holding slot for a write-back port
module rf_wb_slot
  import rf_wb_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    valid_i,
  input  wb_req_t req_i,
  input  logic    gnt_i,
  output logic    ready_o,
  output logic    load_o,
  output logic    full_o,
  output wb_req_t slot_o
);

  // A granted slot frees and reloads on the same edge, so one write per cycle flows through.
  assign ready_o = ~full_o | gnt_i;
  assign load_o  = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_o <= 1'b0;
      slot_o <= '0;
    end else if (load_o) begin
      full_o <= 1'b1;
      slot_o <= req_i;
    end else if (gnt_i) begin
      full_o <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-port round-robin write-back arbiter with same-address ordering
module rf_wb_arbiter #(
  parameter int XLEN = rf_wb_pkg::XLEN,
  parameter int AW   = rf_wb_pkg::AW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0][AW-1:0]   req_addr_i,
  input  logic [1:0][XLEN-1:0] req_data_i,
  output logic                 rf_we_o,
  output logic [AW-1:0]        rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  input  logic [AW-1:0]        lookup_addr_i,
  output logic                 lookup_hit_o,
  output logic                 idle_o
);

  import rf_wb_pkg::*;

  logic [1:0] full;
  logic [1:0] load;
  logic [1:0] gnt;
  logic [1:0] stay;
  logic [1:0] old_q;
  logic       rr_last_q;
  wb_req_t    slot [N_WB_PORTS];
  wb_req_t    gnt_req;

  for (genvar i = 0; i < N_WB_PORTS; i++) begin : g_slot
    rf_wb_slot u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (req_valid_i[i]),
      .req_i   ('{addr: req_addr_i[i], data: req_data_i[i]}),
      .gnt_i   (gnt[i]),
      .ready_o (req_ready_o[i]),
      .load_o  (load[i]),
      .full_o  (full[i]),
      .slot_o  (slot[i])
    );
  end

  // Same-address pairs go oldest first; otherwise favour the port not granted last.
  always_comb begin
    gnt = 2'b00;
    case (full)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (slot[0].addr == slot[1].addr) gnt = old_q[1] ? 2'b10 : 2'b01;
        else                              gnt = rr_last_q ? 2'b01 : 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

  assign stay    = full & ~gnt;
  assign gnt_req = gnt[1] ? slot[1] : slot[0];

  // Age is only consulted with both slots full, which always follows a load, so loads alone update it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      old_q     <= 2'b00;
      rr_last_q <= 1'b1;
    end else begin
      if (|load) old_q <= {load[0] & stay[1], load[1] & stay[0]};
      if (|gnt)  rr_last_q <= gnt[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (|gnt) begin
      rf_we_o    <= (gnt_req.addr != '0);
      rf_waddr_o <= gnt_req.addr;
      rf_wdata_o <= gnt_req.data;
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

  assign lookup_hit_o = (lookup_addr_i != '0) &&
                        ((full[0] && slot[0].addr == lookup_addr_i) ||
                         (full[1] && slot[1].addr == lookup_addr_i) ||
                         (rf_we_o && rf_waddr_o == lookup_addr_i));

  assign idle_o = ~|full & ~rf_we_o;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 32×32 register file's single write port. Two producers, the ALU/CSR write-back (port 0) and the load unit (port 1), each present writes over a valid/ready handshake. Each port has a one-entry holding slot. The block arbitrates round-robin with same-address ordering protection and drives the register file write port from registered outputs. It also provides a pending-write lookup so the decoder can stall on read-after-write hazards.

## Interface
Parameters:
- `XLEN`, 32, data width
- `AW`, 5, register address width

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  2  per-port write request valid
- `req_ready_o`  out  2  per-port slot can accept this cycle
- `req_addr_i`  in  2×AW  per-port destination register
- `req_data_i`  in  2×XLEN  per-port write data
- `rf_we_o`  out  1  register file write enable (registered)
- `rf_waddr_o`  out  AW  register file write address (registered)
- `rf_wdata_o`  out  XLEN  register file write data (registered)
- `lookup_addr_i`  in  AW  decoder source register to check
- `lookup_hit_o`  out  1  a write to `lookup_addr_i` is still pending
- `idle_o`  out  1  both slots empty and `rf_we_o` low

## Operation
- Slot `i` loads `{addr, data}` and sets `full[i]` on any edge where `req_valid_i[i] & req_ready_o[i]`.
- `req_ready_o[i] = ~full[i] | gnt[i]`. The grant frees the slot in the same edge it is reloaded, which gives one write per cycle per port. There is no combinational path from `req_valid_i` to `req_ready_o`.
- Grant, combinational from slot state only:
  - One slot full: grant it.
  - Both slots full with equal `addr`: grant the slot with age bit `old` set. If both were loaded on the same edge, port 0 goes first.
  - Both slots full with different `addr`: round-robin. Grant the port not granted last. After reset the pointer favours port 0.
- Age bit: when a slot loads while the other slot is full and not granted that cycle, the loading slot is marked younger and the other slot older.
- Output stage: on the grant edge, `rf_waddr_o`/`rf_wdata_o` take the granted slot's contents. `rf_we_o <= 1` unless `addr == 0`. A write to x0 is consumed and frees its slot but produces `rf_we_o = 0`.
- With no grant, `rf_we_o <= 0`. Address and data hold their last values.
- `lookup_hit_o = (lookup_addr_i != 0)` AND the address matches any of:
  - full slot 0 `addr`
  - full slot 1 `addr`
  - `rf_waddr_o` while `rf_we_o` is high
- Reset, asynchronous with `rst_ni = 0`:
  - `full = 00`, age cleared, round-robin pointer at port 0
  - `rf_we_o = 0`, `rf_waddr_o = 0`, `rf_wdata_o = 0`
  - `req_ready_o = 11`, `lookup_hit_o = 0`, `idle_o = 1`
  - Writes in flight at reset are discarded.

## Timing
- Request accepted at edge N: its slot is full during cycle N+1 and is granted in N+1 if it wins arbitration. `rf_we_o` is high during cycle N+2. The register file captures the write at edge N+3.
- The losing slot waits exactly one cycle when both ports are continuously busy, so worst-case wait is 1 grant.
- Sustained throughput: one write per cycle total, alternating ports under full load.
- `lookup_hit_o` stays high from the cycle after acceptance through the cycle in which `rf_we_o` is high for that address. It is combinational on `lookup_addr_i`.
- Both ports valid on the same edge with both slots empty: both load on that edge. Port 0 is granted first, port 1 one cycle later.
- Reset deasserts synchronously to `clk_i` through an external synchronizer. The first accept is possible at the first edge after release.

## Structure
- Package `rf_wb_pkg`:
  - `XLEN` and `AW` constants
  - `typedef struct packed { logic [AW-1:0] addr; logic [XLEN-1:0] data; } wb_req_t`
  - `N_WB_PORTS = 2`
- Sub-module `rf_wb_slot`: one-entry holding register with `full` flag and ready logic. It is instantiated twice.
- Arbitration, age tracking, output register and lookup logic live in `rf_wb_arbiter`.
- `rf_wb_arbiter` sits directly in front of `register_file`: `rf_we_o` connects to `write_enable_i`, `rf_waddr_o` to `write_addr_i`, and `rf_wdata_o` to `write_data_i`.

## Test plan
- Single write: port 0 sends x5 = `0xDEADBEEF` at edge 0. Required: `rf_we_o` = 1 with addr 5 and that data during cycle 2; readback of x5 gives `0xDEADBEEF`; `idle_o` returns to 1 in cycle 3.
- x0 drop: port 1 writes x0 = `0x12345678`. Required: handshake completes, `rf_we_o` never asserts, `lookup_hit_o` for addr 0 stays 0.
- Contention: both ports valid every cycle for 8 cycles, writing different registers. Required:
  - `rf_waddr_o` alternates port 0, port 1, and so on
  - one write per cycle
  - each `req_ready_o` is low for no more than 1 consecutive cycle
- Same-address ordering: port 1 writes x7 = `1` at edge 0 and is stalled behind a full port-0 slot; port 0 writes x7 = `2` at edge 1. Required: the register file writes 1 then 2, and final x7 = `2`.
- Hazard lookup: after accepting x9, `lookup_addr_i = 9`. Required: `lookup_hit_o` = 1 through the `rf_we_o` cycle and 0 the cycle after; `lookup_addr_i = 10` gives 0 throughout.
- Reset mid-operation: assert `rst_ni = 0` with both slots full. Required: immediately `rf_we_o = 0`, `req_ready_o = 11`, `idle_o = 1`, and neither pending write reaches the register file.
